// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract engine with a start/busy/done handshake.
// Sequences a 1-bit full-adder cell (fa2) over WIDTH-bit operands, LSB first.
// Optional build macro SERIAL_ADD_DIGIT2_EN: two chained cells retire two bits per cycle
// (WIDTH must then be even and >= 4).

// 1-bit full-adder cell
module fa2 (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
`ifdef SERIAL_ADD_DIGIT2_EN
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH / 2 - 1);
`else
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_busy;
    logic               r_done;
    logic               r_cout;
    logic               r_ovf;

    logic               w_s0;
    logic               w_c0;
    logic [WIDTH-1:0]   w_result_next;
    logic [WIDTH-1:0]   w_sa_next;
    logic [WIDTH-1:0]   w_sb_next;
    logic               w_carry_next;
    logic               w_ovf_step;

    // Low-order cell: always consumes the current LSB of each operand
    fa2 u_fa0 (
        .i_a  (r_sa[0]),
        .i_b  (r_sb[0]),
        .i_ci (r_carry),
        .o_s  (w_s0),
        .o_co (w_c0)
    );

`ifdef SERIAL_ADD_DIGIT2_EN
    logic w_s1;
    logic w_c1;

    // High-order cell chained on the low cell's carry
    fa2 u_fa1 (
        .i_a  (r_sa[1]),
        .i_b  (r_sb[1]),
        .i_ci (w_c0),
        .o_s  (w_s1),
        .o_co (w_c1)
    );

    assign w_result_next = {w_s1, w_s0, r_result[WIDTH-1:2]};
    assign w_sa_next     = {2'b00, r_sa[WIDTH-1:2]};
    assign w_sb_next     = {2'b00, r_sb[WIDTH-1:2]};
    assign w_carry_next  = w_c1;
    // On the final step w_c0 is the carry into the MSB
    assign w_ovf_step    = w_c0 ^ w_c1;
`else
    assign w_result_next = {w_s0, r_result[WIDTH-1:1]};
    assign w_sa_next     = {1'b0, r_sa[WIDTH-1:1]};
    assign w_sb_next     = {1'b0, r_sb[WIDTH-1:1]};
    assign w_carry_next  = w_c0;
    // On the final step r_carry is the carry into the MSB
    assign w_ovf_step    = r_carry ^ w_c0;
`endif

    // Control FSM, datapath shift registers and registered handshake outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sa     <= a;
                        r_sb     <= op_sub ? ~b : b;
                        r_carry  <= op_sub;
                        r_cnt    <= '0;
                        r_result <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_result <= w_result_next;
                    r_sa     <= w_sa_next;
                    r_sb     <= w_sb_next;
                    r_carry  <= w_carry_next;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        r_cout  <= w_carry_next;
                        r_ovf   <= w_ovf_step;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign result   = r_result;
    assign cout     = r_cout;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 (either build).
module tb_serial_add_ctrl;
    localparam int W = 8;
`ifdef SERIAL_ADD_DIGIT2_EN
    localparam int LAT = W / 2;
`else
    localparam int LAT = W;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op_sub   (op_sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         op;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t sb_q[$];
    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: two's-complement add/subtract with carry and signed overflow
    function automatic vec_t model(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vop);
        vec_t         v;
        logic [W-1:0] bb;
        logic [W:0]   s;
        bb    = vop ? ~vb : vb;
        s     = {1'b0, va} + {1'b0, bb} + {{W{1'b0}}, vop};
        v.a   = va;
        v.b   = vb;
        v.op  = vop;
        v.res = s[W-1:0];
        v.co  = s[W];
        v.ov  = (va[W-1] == bb[W-1]) && (s[W-1] != va[W-1]);
        return v;
    endfunction

    // Issue one operation, optionally poke start during RUN, and score the result
    task automatic run_op(input vec_t v, input bit poke_busy);
        int   n;
        int   busy_cyc;
        bit   got;
        vec_t e;
        @(negedge clk);
        start  = 1'b1;
        a      = v.a;
        b      = v.b;
        op_sub = v.op;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        start    = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        op_sub   = 1'($urandom);
        busy_cyc = busy ? 1 : 0;
        got      = 1'b0;
        n        = 0;
        while (!got && n < 4 * W) begin
            if (poke_busy && n == 1) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
                op_sub = 1'b0;
            end else if (poke_busy && n == 2) begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
            if (busy) busy_cyc++;
            if (done) got = 1'b1;
        end
        chk("done_seen", 32'(got), 32'd1);
        if (!got) return;
        chk("done_latency", 32'(n), 32'(LAT));
        e = sb_q.pop_front();
        chk("result", 32'(result), 32'(e.res));
        chk("cout", 32'(cout), 32'(e.co));
        chk("overflow", 32'(overflow), 32'(e.ov));
        @(posedge clk);
        #1;
        chk("done_pulse_width", 32'(done), 32'd0);
        chk("busy_cycles", 32'(busy_cyc), 32'(LAT + 1));
        chk("busy_fall", 32'(busy), 32'd0);
        chk("result_held", 32'(result), 32'(e.res));
    endtask

    initial begin
        int   seen;
        vec_t v;

        tbl[0] = '{a: 8'h3C, b: 8'h05, op: 1'b0, res: 8'h41, co: 1'b0, ov: 1'b0};
        tbl[1] = '{a: 8'h7F, b: 8'h01, op: 1'b0, res: 8'h80, co: 1'b0, ov: 1'b1};
        tbl[2] = '{a: 8'h05, b: 8'h07, op: 1'b1, res: 8'hFE, co: 1'b0, ov: 1'b0};
        tbl[3] = '{a: 8'h80, b: 8'h01, op: 1'b1, res: 8'h7F, co: 1'b1, ov: 1'b1};
        tbl[4] = '{a: 8'hFF, b: 8'h01, op: 1'b0, res: 8'h00, co: 1'b1, ov: 1'b0};

        reset_n = 1'b0;
        start   = 1'b0;
        op_sub  = 1'b0;
        a       = '0;
        b       = '0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table vectors, with start poked while busy on the first one
        for (int i = 0; i < 5; i++) run_op(tbl[i], i == 0);

        // Random vectors scored against the model
        for (int i = 0; i < 8; i++) begin
            v = model(W'($urandom), W'($urandom), 1'($urandom));
            run_op(v, 1'b0);
        end

        // Reset while idle with a non-zero result held
        run_op(tbl[3], 1'b0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("idle_rst_result", 32'(result), 32'd0);
        chk("idle_rst_cout", 32'(cout), 32'd0);
        chk("idle_rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset mid-RUN aborts without a done
        @(negedge clk);
        start  = 1'b1;
        a      = 8'h3C;
        b      = 8'h05;
        op_sub = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("run_busy_before_rst", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("run_rst_busy", 32'(busy), 32'd0);
        chk("run_rst_done", 32'(done), 32'd0);
        chk("run_rst_result", 32'(result), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 2 * W + 4; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        chk("no_done_after_abort", 32'(seen), 32'd0);

        // Engine still healthy after the abort
        run_op(tbl[0], 1'b0);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
